// File: rtl/axi_computer_wr_master_if.sv
// AXI3 write-channel bundle (AW, W, B) between the computer write master and the interconnect.
interface axi_computer_wr_master_if;
  logic [11:0] awid;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [11:0] wid;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic [11:0] bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awvalid, awaddr, awlen, awsize, awburst,
    output wid, wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awvalid, awaddr, awlen, awsize, awburst,
    input  wid, wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_computer_wr_master.sv
// Single-beat AXI3 write initiator for the computer core; one request in flight at a time.
// Optional bid check against ID is enabled by defining AXI_COMPUTER_WR_ID_CHECK_EN.
module axi_computer_wr_master #(
  parameter logic [11:0] ID              = 12'h000,
  parameter int unsigned ALLOW_UNALIGNED = 0
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [31:0]                     req_addr_i,
  input  logic [31:0]                     req_data_i,
  input  logic [3:0]                      req_strb_i,
  output logic                            done_o,
  output logic                            done_error_o,
  output logic [2:0]                      done_code_o,
  axi_computer_wr_master_if.master        axi
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, FAIL} state_e;

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        done_q, done_d;
  logic        done_error_q, done_error_d;
  logic [2:0]  done_code_q, done_code_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  strb_q, strb_d;
  logic        id_mismatch;

`ifdef AXI_COMPUTER_WR_ID_CHECK_EN
  assign id_mismatch = (axi.bid != ID);
`else
  assign id_mismatch = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    done_d       = 1'b0;
    done_error_d = done_error_q;
    done_code_d  = done_code_q;
    addr_d       = addr_q;
    data_d       = data_q;
    strb_d       = strb_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_q) begin
          addr_d = req_addr_i;
          data_d = req_data_i;
          strb_d = req_strb_i;
          if ((ALLOW_UNALIGNED == 0) && (req_addr_i[1:0] != 2'b00)) begin
            state_d = FAIL;
          end else begin
            state_d   = ISSUE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      // AW and W retire independently; the response phase starts once both are gone.
      ISSUE: begin
        if (awvalid_q && axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)  state_d   = RESP;
      end
      RESP: begin
        if (bready_q && axi.bvalid) begin
          state_d      = IDLE;
          done_d       = 1'b1;
          done_code_d  = id_mismatch ? 3'd5 : {1'b0, axi.bresp};
          done_error_d = (done_code_d != 3'd0);
        end
      end
      FAIL: begin
        state_d      = IDLE;
        done_d       = 1'b1;
        done_error_d = 1'b1;
        done_code_d  = 3'd4;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    bready_d    = (state_d == RESP);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      done_q       <= 1'b0;
      done_error_q <= 1'b0;
      done_code_q  <= 3'd0;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      strb_q       <= 4'd0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      done_q       <= done_d;
      done_error_q <= done_error_d;
      done_code_q  <= done_code_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      strb_q       <= strb_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign done_o       = done_q;
  assign done_error_o = done_error_q;
  assign done_code_o  = done_code_q;

  assign axi.awid    = ID;
  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.wid     = ID;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = data_q;
  assign axi.wstrb   = strb_q;
  assign axi.wlast   = 1'b1;
  assign axi.bready  = bready_q;

endmodule

// File: tb/tb_axi_computer_wr_master.sv
// Bench for axi_computer_wr_master: a configurable AXI slave model records each transaction
// into an observed queue that the scenario tasks compare against their expected queue.
module tb_axi_computer_wr_master;

  localparam logic [11:0] TB_ID = 12'h000;

  typedef struct {
    logic [2:0]  code;
    logic        err;
    logic        bus;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  typedef struct {
    logic [2:0]  code;
    logic        err;
    logic        bus;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        meta;
    int          doneCyc;
    int          awCyc;
    int          wCyc;
    int          brCyc;
  } obs_t;

  logic        clk;
  logic        rstn;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqAddr;
  logic [31:0] reqData;
  logic [3:0]  reqStrb;
  logic        done;
  logic        doneError;
  logic [2:0]  doneCode;

  logic        uaReqValid;
  logic        uaReqReady;
  logic [31:0] uaReqAddr;
  logic [31:0] uaReqData;
  logic [3:0]  uaReqStrb;
  logic        uaDone;
  logic        uaDoneError;
  logic [2:0]  uaDoneCode;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int awDelay = 0;
  int wDelay = 0;
  bit bAlways = 0;
  int awvCnt = 0;
  int wvCnt = 0;
  int stableErr = 0;
  int breadyErr = 0;

  logic [13:0] respQ[$];
  exp_t        expQ[$];
  obs_t        obsQ[$];

  axi_computer_wr_master_if axi ();
  axi_computer_wr_master_if uaBus ();

  axi_computer_wr_master #(.ID(TB_ID), .ALLOW_UNALIGNED(0)) u_dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .req_valid_i  (reqValid),
    .req_ready_o  (reqReady),
    .req_addr_i   (reqAddr),
    .req_data_i   (reqData),
    .req_strb_i   (reqStrb),
    .done_o       (done),
    .done_error_o (doneError),
    .done_code_o  (doneCode),
    .axi          (axi.master)
  );

  axi_computer_wr_master #(.ID(TB_ID), .ALLOW_UNALIGNED(1)) u_dut_ua (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .req_valid_i  (uaReqValid),
    .req_ready_o  (uaReqReady),
    .req_addr_i   (uaReqAddr),
    .req_data_i   (uaReqData),
    .req_strb_i   (uaReqStrb),
    .done_o       (uaDone),
    .done_error_o (uaDoneError),
    .done_code_o  (uaDoneCode),
    .axi          (uaBus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t fresh_obs();
    obs_t o;
    o.code = 3'h7; o.err = 1'bx; o.bus = 1'b0;
    o.addr = '0; o.data = '0; o.strb = '0; o.meta = 1'b0;
    o.doneCyc = -1; o.awCyc = -1; o.wCyc = -1; o.brCyc = -1;
    return o;
  endfunction

  // Slave model and monitor share one process so every sample sees the ready values just driven.
  initial begin : busModel
    logic pBv, pBr, pAw, pAwR, pW, pWR;
    logic [31:0] pAddr, pData;
    logic [3:0]  pStrb;
    int awWait, wWait;
    obs_t cur;
    pBv = 0; pBr = 0; pAw = 0; pAwR = 0; pW = 0; pWR = 0;
    pAddr = '0; pData = '0; pStrb = '0; awWait = 0; wWait = 0;
    cur = fresh_obs();
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.bid = TB_ID;
    forever begin
      @(negedge clk);
      if (pBv && pBr && respQ.size() > 0) respQ.delete(0);
      awWait = axi.awvalid ? awWait + 1 : 0;
      wWait  = axi.wvalid ? wWait + 1 : 0;
      axi.awready = axi.awvalid && (awWait > awDelay);
      axi.wready  = axi.wvalid && (wWait > wDelay);
      axi.bvalid  = bAlways || axi.bready;
      if (respQ.size() > 0) {axi.bid, axi.bresp} = respQ[0];
      else {axi.bid, axi.bresp} = {TB_ID, 2'b00};

      if (!rstn) begin
        pAw = 0; pW = 0;
        cur = fresh_obs();
      end else begin
        if (pAw && !pAwR && (!axi.awvalid || axi.awaddr !== pAddr)) stableErr++;
        if (pW && !pWR && (!axi.wvalid || axi.wdata !== pData || axi.wstrb !== pStrb)) stableErr++;
        if (axi.bready && (axi.awvalid || axi.wvalid)) breadyErr++;
        if (axi.awvalid) begin awvCnt++; cur.bus = 1'b1; end
        if (axi.wvalid) begin wvCnt++; cur.bus = 1'b1; end
        if (axi.awvalid && axi.awready) begin
          cur.awCyc = cyc;
          cur.addr  = axi.awaddr;
          cur.meta  = (axi.awlen == 8'd0) && (axi.awsize == 3'b010) && (axi.awburst == 2'b01) &&
                      (axi.awid == TB_ID);
        end
        if (axi.wvalid && axi.wready) begin
          cur.wCyc = cyc;
          cur.data = axi.wdata;
          cur.strb = axi.wstrb;
          cur.meta = cur.meta && axi.wlast && (axi.wid == TB_ID);
        end
        if (axi.bready && cur.brCyc < 0) cur.brCyc = cyc;
        if (done) begin
          cur.code    = doneCode;
          cur.err     = doneError;
          cur.doneCyc = cyc;
          obsQ.push_back(cur);
          cur = fresh_obs();
        end
        pAw = axi.awvalid; pAwR = axi.awready; pAddr = axi.awaddr;
        pW = axi.wvalid; pWR = axi.wready; pData = axi.wdata; pStrb = axi.wstrb;
      end
      pBv = axi.bvalid; pBr = axi.bready;
    end
  end

  initial begin
    uaBus.awready = 1'b1; uaBus.wready = 1'b1; uaBus.bvalid = 1'b1;
    uaBus.bresp = 2'b00; uaBus.bid = TB_ID;
  end

  task automatic send_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int acc);
    int n;
    n = 0;
    @(negedge clk);
    reqValid = 1'b1; reqAddr = a; reqData = d; reqStrb = s;
    while (reqReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = (n < 50) ? cyc : -1;
    @(posedge clk);
    #1 reqValid = 1'b0;
  endtask

  task automatic wait_obs(output bit ok);
    int n;
    n = 0;
    while (obsQ.size() == 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = (obsQ.size() > 0);
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #1;
    total++; if (reqReady !== 1'b1) begin bad++; $display("[TB] FAIL rst_req_ready got=%b exp=1", reqReady); end
    total++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b000) begin bad++;
      $display("[TB] FAIL rst_valids got=%b exp=000", {axi.awvalid, axi.wvalid, axi.bready}); end
    total++; if ({done, doneError, doneCode} !== 5'd0) begin bad++;
      $display("[TB] FAIL rst_done got=%b exp=00000", {done, doneError, doneCode}); end
    total++; if ({axi.awaddr, axi.wdata, axi.wstrb} !== 68'd0) begin bad++;
      $display("[TB] FAIL rst_bus got=%h exp=0", {axi.awaddr, axi.wdata, axi.wstrb}); end
    total++; if ({axi.awid, axi.awlen, axi.awsize, axi.awburst, axi.wid, axi.wlast} !==
                 {TB_ID, 8'd0, 3'b010, 2'b01, TB_ID, 1'b1}) begin bad++;
      $display("[TB] FAIL rst_consts got=%h exp=%h",
               {axi.awid, axi.awlen, axi.awsize, axi.awburst, axi.wid, axi.wlast},
               {TB_ID, 8'd0, 3'b010, 2'b01, TB_ID, 1'b1}); end
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_ready_everywhere();
    exp_t e; obs_t o; int acc; bit ok;
    bAlways = 1;
    e = '{code: 3'd0, err: 1'b0, bus: 1'b1, addr: 32'h4000_0000, data: 32'hDEAD_BEEF, strb: 4'hF};
    expQ.push_back(e);
    send_req(e.addr, e.data, e.strb, acc);
    wait_obs(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL rdy_timeout got=none exp=done"); end
    if (ok) o = obsQ.pop_front(); else o = fresh_obs();
    e = expQ.pop_front();
    total++; if ({o.code, o.err} !== {e.code, e.err}) begin bad++;
      $display("[TB] FAIL rdy_status got=%h exp=%h", {o.code, o.err}, {e.code, e.err}); end
    total++; if (o.doneCyc !== acc + 3) begin bad++;
      $display("[TB] FAIL rdy_done_cycle got=%0d exp=%0d", o.doneCyc, acc + 3); end
    total++; if ({o.addr, o.data, o.strb} !== {e.addr, e.data, e.strb}) begin bad++;
      $display("[TB] FAIL rdy_payload got=%h exp=%h", {o.addr, o.data, o.strb}, {e.addr, e.data, e.strb}); end
    total++; if (o.meta !== 1'b1) begin bad++; $display("[TB] FAIL rdy_meta got=%b exp=1", o.meta); end
    total++; if (o.awCyc !== acc + 1 || o.wCyc !== acc + 1) begin bad++;
      $display("[TB] FAIL rdy_hs_cycle got=%0d/%0d exp=%0d", o.awCyc, o.wCyc, acc + 1); end
    total++; if (o.brCyc !== acc + 2) begin bad++;
      $display("[TB] FAIL rdy_bready_cycle got=%0d exp=%0d", o.brCyc, acc + 2); end
    repeat (4) begin @(negedge clk); #1; end
    total++; if (obsQ.size() !== 0) begin bad++;
      $display("[TB] FAIL rdy_extra_done got=%0d exp=0", obsQ.size()); end
    bAlways = 0;
  endtask

  task automatic test_skewed();
    exp_t e; obs_t o; int acc; bit ok;
    int awv0, wv0, se0, be0;
    wDelay = 5;
    awv0 = awvCnt; wv0 = wvCnt; se0 = stableErr; be0 = breadyErr;
    e = '{code: 3'd0, err: 1'b0, bus: 1'b1, addr: 32'h5000_0010, data: 32'h1234_5678, strb: 4'h3};
    expQ.push_back(e);
    send_req(e.addr, e.data, e.strb, acc);
    wait_obs(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL skew_timeout got=none exp=done"); end
    if (ok) o = obsQ.pop_front(); else o = fresh_obs();
    e = expQ.pop_front();
    total++; if ({o.code, o.err} !== {e.code, e.err}) begin bad++;
      $display("[TB] FAIL skew_status got=%h exp=%h", {o.code, o.err}, {e.code, e.err}); end
    total++; if (o.awCyc !== acc + 1) begin bad++;
      $display("[TB] FAIL skew_aw_cycle got=%0d exp=%0d", o.awCyc, acc + 1); end
    total++; if (o.wCyc !== acc + 6) begin bad++;
      $display("[TB] FAIL skew_w_cycle got=%0d exp=%0d", o.wCyc, acc + 6); end
    total++; if (o.brCyc !== acc + 7) begin bad++;
      $display("[TB] FAIL skew_bready_cycle got=%0d exp=%0d", o.brCyc, acc + 7); end
    total++; if (o.doneCyc !== acc + 8) begin bad++;
      $display("[TB] FAIL skew_done_cycle got=%0d exp=%0d", o.doneCyc, acc + 8); end
    total++; if ({o.data, o.strb} !== {e.data, e.strb}) begin bad++;
      $display("[TB] FAIL skew_wdata got=%h exp=%h", {o.data, o.strb}, {e.data, e.strb}); end
    total++; if (awvCnt - awv0 !== 1 || wvCnt - wv0 !== 6) begin bad++;
      $display("[TB] FAIL skew_valid_cycles got=%0d/%0d exp=1/6", awvCnt - awv0, wvCnt - wv0); end
    total++; if (stableErr !== se0 || breadyErr !== be0) begin bad++;
      $display("[TB] FAIL skew_protocol got=%0d/%0d exp=%0d/%0d", stableErr, breadyErr, se0, be0); end
    repeat (3) begin @(negedge clk); #1; end
    total++; if (obsQ.size() !== 0) begin bad++;
      $display("[TB] FAIL skew_extra_done got=%0d exp=0", obsQ.size()); end
    wDelay = 0;
  endtask

  task automatic test_error_back_to_back();
    exp_t e; obs_t o; int acc1, acc2; bit ok;
    respQ.push_back({TB_ID, 2'b10});
    respQ.push_back({TB_ID, 2'b11});
    e = '{code: 3'd2, err: 1'b1, bus: 1'b1, addr: 32'h4000_0020, data: 32'h0000_0001, strb: 4'hF};
    expQ.push_back(e);
    e = '{code: 3'd3, err: 1'b1, bus: 1'b1, addr: 32'h4000_0024, data: 32'h0000_0002, strb: 4'hF};
    expQ.push_back(e);
    send_req(32'h4000_0020, 32'h0000_0001, 4'hF, acc1);
    send_req(32'h4000_0024, 32'h0000_0002, 4'hF, acc2);
    for (int k = 0; k < 2; k++) begin
      wait_obs(ok);
      total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL err_timeout got=none exp=done%0d", k); end
      if (ok) o = obsQ.pop_front(); else o = fresh_obs();
      e = expQ.pop_front();
      total++; if ({o.code, o.err} !== {e.code, e.err}) begin bad++;
        $display("[TB] FAIL err_status%0d got=%h exp=%h", k, {o.code, o.err}, {e.code, e.err}); end
      if (k == 0) begin
        total++; if (acc2 !== o.doneCyc) begin bad++;
          $display("[TB] FAIL err_accept_on_done got=%0d exp=%0d", acc2, o.doneCyc); end
      end
    end
    repeat (2) begin @(negedge clk); #1; end
    total++; if ({done, doneError, doneCode} !== {1'b0, 1'b1, 3'd3}) begin bad++;
      $display("[TB] FAIL err_status_hold got=%b exp=01011", {done, doneError, doneCode}); end
  endtask

  task automatic test_misaligned();
    exp_t e; obs_t o; int acc, uaAcc, uaDoneCyc; bit ok;
    logic [31:0] uaAddr;
    logic [2:0]  uaCodeSeen;
    e = '{code: 3'd4, err: 1'b1, bus: 1'b0, addr: 32'h4000_0002, data: 32'h0BAD_F00D, strb: 4'hF};
    expQ.push_back(e);
    send_req(e.addr, e.data, e.strb, acc);
    wait_obs(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL mis_timeout got=none exp=done"); end
    if (ok) o = obsQ.pop_front(); else o = fresh_obs();
    e = expQ.pop_front();
    total++; if ({o.code, o.err} !== {e.code, e.err}) begin bad++;
      $display("[TB] FAIL mis_status got=%h exp=%h", {o.code, o.err}, {e.code, e.err}); end
    total++; if (o.bus !== e.bus) begin bad++; $display("[TB] FAIL mis_bus_activity got=%b exp=0", o.bus); end
    total++; if (o.doneCyc !== acc + 2) begin bad++;
      $display("[TB] FAIL mis_done_cycle got=%0d exp=%0d", o.doneCyc, acc + 2); end

    @(negedge clk);
    uaReqValid = 1'b1; uaReqAddr = 32'h4000_0002; uaReqData = 32'h0BAD_F00D; uaReqStrb = 4'hF;
    uaAcc = cyc;
    total++; if (uaReqReady !== 1'b1) begin bad++; $display("[TB] FAIL ua_ready got=%b exp=1", uaReqReady); end
    @(posedge clk);
    #1 uaReqValid = 1'b0;
    uaDoneCyc = -1; uaAddr = '0; uaCodeSeen = 3'h7;
    for (int n = 0; n < 20 && uaDoneCyc < 0; n++) begin
      @(negedge clk);
      #1;
      if (uaBus.awvalid && uaBus.awready) uaAddr = uaBus.awaddr;
      if (uaDone) begin uaDoneCyc = cyc; uaCodeSeen = uaDoneCode; end
    end
    total++; if (uaDoneCyc !== uaAcc + 3) begin bad++;
      $display("[TB] FAIL ua_done_cycle got=%0d exp=%0d", uaDoneCyc, uaAcc + 3); end
    total++; if (uaAddr !== 32'h4000_0002) begin bad++;
      $display("[TB] FAIL ua_awaddr got=%h exp=40000002", uaAddr); end
    total++; if (uaCodeSeen !== 3'd0) begin bad++;
      $display("[TB] FAIL ua_code got=%0d exp=0", uaCodeSeen); end
  endtask

  task automatic test_id_check();
    exp_t e; obs_t o; int acc; bit ok;
    respQ.push_back({12'h005, 2'b00});
    e = '{code: 3'd0, err: 1'b0, bus: 1'b1, addr: 32'h4000_0040, data: 32'hCAFE_0005, strb: 4'hF};
`ifdef AXI_COMPUTER_WR_ID_CHECK_EN
    e.code = 3'd5; e.err = 1'b1;
`endif
    expQ.push_back(e);
    send_req(e.addr, e.data, e.strb, acc);
    wait_obs(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL id_timeout got=none exp=done"); end
    if (ok) o = obsQ.pop_front(); else o = fresh_obs();
    e = expQ.pop_front();
    total++; if ({o.code, o.err} !== {e.code, e.err}) begin bad++;
      $display("[TB] FAIL id_status got=%h exp=%h", {o.code, o.err}, {e.code, e.err}); end
  endtask

  task automatic test_reset_mid();
    exp_t e; obs_t o; int acc; bit ok;
    logic preAw;
    awDelay = 20; wDelay = 20;
    e = '{code: 3'd0, err: 1'b0, bus: 1'b1, addr: 32'h4000_0100, data: 32'hA5A5_5A5A, strb: 4'hF};
    expQ.push_back(e);
    send_req(e.addr, e.data, e.strb, acc);
    #2 preAw = axi.awvalid;
    rstn = 1'b0;
    #1;
    total++; if (preAw !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_awvalid got=%b exp=1", preAw); end
    total++; if ({reqReady, axi.awvalid, axi.wvalid, axi.bready, done} !== 5'b10000) begin bad++;
      $display("[TB] FAIL mid_async_reset got=%b exp=10000",
               {reqReady, axi.awvalid, axi.wvalid, axi.bready, done}); end
    total++; if ({axi.awaddr, axi.wdata, axi.wstrb} !== 68'd0) begin bad++;
      $display("[TB] FAIL mid_bus_cleared got=%h exp=0", {axi.awaddr, axi.wdata, axi.wstrb}); end
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    expQ.delete();
    obsQ.delete();
    awDelay = 0; wDelay = 0;
    total++; if (reqReady !== 1'b1) begin bad++; $display("[TB] FAIL mid_ready_after got=%b exp=1", reqReady); end
    e = '{code: 3'd0, err: 1'b0, bus: 1'b1, addr: 32'h4000_0200, data: 32'h7777_1111, strb: 4'hC};
    expQ.push_back(e);
    send_req(e.addr, e.data, e.strb, acc);
    wait_obs(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL mid_timeout got=none exp=done"); end
    if (ok) o = obsQ.pop_front(); else o = fresh_obs();
    e = expQ.pop_front();
    total++; if ({o.code, o.err, o.addr, o.data, o.strb} !== {e.code, e.err, e.addr, e.data, e.strb}) begin bad++;
      $display("[TB] FAIL mid_fresh_write got=%h exp=%h",
               {o.code, o.err, o.addr, o.data, o.strb}, {e.code, e.err, e.addr, e.data, e.strb}); end
    total++; if (o.doneCyc !== acc + 3) begin bad++;
      $display("[TB] FAIL mid_fresh_done_cycle got=%0d exp=%0d", o.doneCyc, acc + 3); end
  endtask

  initial begin
    rstn = 1'b1;
    reqValid = 1'b0; reqAddr = '0; reqData = '0; reqStrb = '0;
    uaReqValid = 1'b0; uaReqAddr = '0; uaReqData = '0; uaReqStrb = '0;
    $display("[TB] starting axi_computer_wr_master bench");
    test_reset();
    test_ready_everywhere();
    test_skewed();
    test_error_back_to_back();
    test_misaligned();
    test_id_check();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
